// File: rtl/axil_regbank_pkg.sv
// Shared constants and types for the AXI4-Lite register bank: response codes,
// FSM state encodings and the register-index width helper.
package axil_regbank_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {
        W_IDLE,
        W_RESP
    } wr_state_e;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } rd_state_e;

    // Address bits left once the byte offset within a data word is dropped.
    function automatic int idx_width(input int addr_w, input int data_w);
        return addr_w - $clog2(data_w / 8);
    endfunction

endpackage

// File: rtl/axil_regbank_wstrb_merge.sv
// Byte-lane merge: each byte with its strobe set takes the new write data,
// all other bytes keep the old register contents.
module axil_regbank_wstrb_merge
    import axil_regbank_pkg::*;
#(
    parameter int C_DATA_WIDTH = 32
) (
    input  logic [C_DATA_WIDTH-1:0]   old_i,
    input  logic [C_DATA_WIDTH-1:0]   wdata_i,
    input  logic [C_DATA_WIDTH/8-1:0] wstrb_i,
    output logic [C_DATA_WIDTH-1:0]   merged_o
);

    always_comb begin
        merged_o = old_i;
        for (int b = 0; b < C_DATA_WIDTH / 8; b++) begin
            if (wstrb_i[b]) begin
                merged_o[8*b +: 8] = wdata_i[8*b +: 8];
            end
        end
    end

endmodule

// File: rtl/axil_regbank.sv
// Parametrised AXI4-Lite slave register bank with byte strobes, read-only
// status registers, per-register write pulses and SLVERR on bad accesses.
module axil_regbank
    import axil_regbank_pkg::*;
#(
    parameter int          C_DATA_WIDTH = 32,
    parameter int          C_NUM_REGS   = 8,
    parameter int          C_ADDR_WIDTH = 6,
    parameter logic [63:0] C_RO_MASK    = '0
) (
    input  logic                               ACLK,
    input  logic                               ARESET,
    input  logic [C_ADDR_WIDTH-1:0]            s_axi_awaddr,
    input  logic                               s_axi_awvalid,
    output logic                               s_axi_awready,
    input  logic [C_DATA_WIDTH-1:0]            s_axi_wdata,
    input  logic [C_DATA_WIDTH/8-1:0]          s_axi_wstrb,
    input  logic                               s_axi_wvalid,
    output logic                               s_axi_wready,
    output logic [1:0]                         s_axi_bresp,
    output logic                               s_axi_bvalid,
    input  logic                               s_axi_bready,
    input  logic [C_ADDR_WIDTH-1:0]            s_axi_araddr,
    input  logic                               s_axi_arvalid,
    output logic                               s_axi_arready,
    output logic [C_DATA_WIDTH-1:0]            s_axi_rdata,
    output logic [1:0]                         s_axi_rresp,
    output logic                               s_axi_rvalid,
    input  logic                               s_axi_rready,
    output logic [C_NUM_REGS*C_DATA_WIDTH-1:0] reg_out,
    input  logic [C_NUM_REGS*C_DATA_WIDTH-1:0] reg_in,
    output logic [C_NUM_REGS-1:0]              reg_wr_pulse
);

    localparam int NB  = C_DATA_WIDTH / 8;
    localparam int OFF = $clog2(NB);
    localparam int IW  = idx_width(C_ADDR_WIDTH, C_DATA_WIDTH);

    wr_state_e              wstate_q, wstate_d;
    rd_state_e              rstate_q, rstate_d;
    logic                   aw_held_q, aw_held_d;
    logic [IW-1:0]          awidx_q, awidx_d;
    logic                   w_held_q, w_held_d;
    logic [C_DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [NB-1:0]          wstrb_q, wstrb_d;
    logic [1:0]             bresp_q, bresp_d;
    logic [C_NUM_REGS-1:0]  pulse_q, pulse_d;
    logic [C_DATA_WIDTH-1:0] regs_q [C_NUM_REGS];
    logic [C_DATA_WIDTH-1:0] regs_d [C_NUM_REGS];
    logic [C_DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [1:0]             rresp_q, rresp_d;

    logic                   aw_hs, w_hs, ar_hs, commit, wr_ok;
    logic [IW-1:0]          aridx;
    logic [C_DATA_WIDTH-1:0] old_sel, merged;
    logic                   unused_addr_bits;

    // Byte-offset bits never select anything; fold them into a dummy net.
    assign unused_addr_bits = ^{s_axi_awaddr[OFF-1:0], s_axi_araddr[OFF-1:0]};

    // Readies are forced low while reset is asserted, not just after it.
    assign s_axi_awready = !ARESET && (wstate_q == W_IDLE) && !aw_held_q;
    assign s_axi_wready  = !ARESET && (wstate_q == W_IDLE) && !w_held_q;
    assign s_axi_arready = !ARESET && (rstate_q == R_IDLE);
    assign s_axi_bvalid  = (wstate_q == W_RESP);
    assign s_axi_rvalid  = (rstate_q == R_DATA);
    assign s_axi_bresp   = bresp_q;
    assign s_axi_rresp   = rresp_q;
    assign s_axi_rdata   = rdata_q;
    assign reg_wr_pulse  = pulse_q;

    assign aw_hs  = s_axi_awvalid && s_axi_awready;
    assign w_hs   = s_axi_wvalid && s_axi_wready;
    assign ar_hs  = s_axi_arvalid && s_axi_arready;
    assign commit = (wstate_q == W_IDLE) && aw_held_q && w_held_q;
    assign aridx  = s_axi_araddr[C_ADDR_WIDTH-1:OFF];

    for (genvar g = 0; g < C_NUM_REGS; g++) begin : g_out
        assign reg_out[g*C_DATA_WIDTH +: C_DATA_WIDTH] = regs_q[g];
    end

    // Out-of-range indices match no register, leaving wr_ok low.
    always_comb begin
        old_sel = '0;
        wr_ok   = 1'b0;
        for (int i = 0; i < C_NUM_REGS; i++) begin
            if (int'(awidx_q) == i) begin
                old_sel = regs_q[i];
                wr_ok   = !C_RO_MASK[i];
            end
        end
    end

    axil_regbank_wstrb_merge #(
        .C_DATA_WIDTH (C_DATA_WIDTH)
    ) u_merge (
        .old_i    (old_sel),
        .wdata_i  (wdata_q),
        .wstrb_i  (wstrb_q),
        .merged_o (merged)
    );

    always_comb begin
        wstate_d  = wstate_q;
        aw_held_d = aw_held_q;
        awidx_d   = awidx_q;
        w_held_d  = w_held_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        bresp_d   = bresp_q;
        pulse_d   = '0;
        regs_d    = regs_q;
        if (aw_hs) begin
            aw_held_d = 1'b1;
            awidx_d   = s_axi_awaddr[C_ADDR_WIDTH-1:OFF];
        end
        if (w_hs) begin
            w_held_d = 1'b1;
            wdata_d  = s_axi_wdata;
            wstrb_d  = s_axi_wstrb;
        end
        case (wstate_q)
            W_IDLE: begin
                if (commit) begin
                    wstate_d = W_RESP;
                    bresp_d  = wr_ok ? RESP_OKAY : RESP_SLVERR;
                    for (int i = 0; i < C_NUM_REGS; i++) begin
                        if (wr_ok && int'(awidx_q) == i) begin
                            regs_d[i]  = merged;
                            pulse_d[i] = 1'b1;
                        end
                    end
                end
            end
            W_RESP: begin
                if (s_axi_bready) begin
                    wstate_d  = W_IDLE;
                    aw_held_d = 1'b0;
                    w_held_d  = 1'b0;
                end
            end
            default: wstate_d = W_IDLE;
        endcase
    end

    // Reads sample regs_q before a same-cycle write lands: pre-write value.
    always_comb begin
        rstate_d = rstate_q;
        rdata_d  = rdata_q;
        rresp_d  = rresp_q;
        case (rstate_q)
            R_IDLE: begin
                if (ar_hs) begin
                    rstate_d = R_DATA;
                    rdata_d  = '0;
                    rresp_d  = RESP_SLVERR;
                    for (int i = 0; i < C_NUM_REGS; i++) begin
                        if (int'(aridx) == i) begin
                            rresp_d = RESP_OKAY;
                            rdata_d = C_RO_MASK[i] ? reg_in[i*C_DATA_WIDTH +: C_DATA_WIDTH]
                                                   : regs_q[i];
                        end
                    end
                end
            end
            R_DATA: begin
                if (s_axi_rready) begin
                    rstate_d = R_IDLE;
                end
            end
            default: rstate_d = R_IDLE;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            wstate_q  <= W_IDLE;
            rstate_q  <= R_IDLE;
            aw_held_q <= 1'b0;
            awidx_q   <= '0;
            w_held_q  <= 1'b0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            bresp_q   <= RESP_OKAY;
            pulse_q   <= '0;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
            for (int i = 0; i < C_NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            wstate_q  <= wstate_d;
            rstate_q  <= rstate_d;
            aw_held_q <= aw_held_d;
            awidx_q   <= awidx_d;
            w_held_q  <= w_held_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            bresp_q   <= bresp_d;
            pulse_q   <= pulse_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            for (int i = 0; i < C_NUM_REGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

endmodule
